trace_capture_buffer: RTL

Parametrised on-chip trace recorder for the LFCPNX-EVN SoC. It captures the core's `trace_data`/`trace_valid` stream into a ring or linear buffer and freezes a programmable number of entries after `trap`. It then drains the record oldest-first over a valid/ready port, typically to a UART bridge. Capture and drain run on one clock, with no CPU involvement.

---
 rtl/trace_capture_buffer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/trace_capture_buffer.sv
// Trace capture buffer: records a trace stream, freezes after a trap, drains oldest-first.
// Define TRACE_CAPTURE_TIMESTAMP_EN to tag each entry with a free-running timestamp.
module trace_capture_buffer #(
  parameter int DATA_WIDTH   = 36,
  parameter int DEPTH        = 512,
  parameter int POST_TRIGGER = 8,
  parameter int RING_MODE    = 1,
  parameter int TS_WIDTH     = 32,
`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  localparam int OUT_WIDTH   = DATA_WIDTH + TS_WIDTH
`else
  localparam int OUT_WIDTH   = DATA_WIDTH
`endif
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    arm,
  input  logic                    trace_valid,
  input  logic [DATA_WIDTH-1:0]   trace_data,
  input  logic                    trap,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic [1:0]              state,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    POST    = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  state_t               st;
  logic [OUT_WIDTH-1:0] mem [DEPTH];
  logic [OUT_WIDTH-1:0] entry;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        post_cnt;
  logic                 capturing;
  logic                 full;
  logic                 do_write;
  logic                 pop;
  logic                 more;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || TS_WIDTH < 1) begin : g_bad_param
    $error("trace_capture_buffer: bad DEPTH or TS_WIDTH");
  end

`ifdef TRACE_CAPTURE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      ts <= '0;
    else if (arm)
      ts <= '0;
    else
      ts <= ts + TS_WIDTH'(1);
  end

  assign entry = {ts, trace_data};
`else
  assign entry = trace_data;
`endif

  assign capturing = !arm && trace_valid &&
                     (st == CAPTURE || st == POST);
  assign full      = count == CW'(DEPTH);
  assign do_write  = capturing && (!full || RING_MODE != 0);
  assign pop       = out_valid && out_ready;
  // words still in memory, not yet moved into the output register
  assign more      = count != CW'(out_valid);
  assign state     = st;

  always_ff @(posedge clock) begin
    if (do_write)
      mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (arm) begin
      st        <= CAPTURE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      unique case (st)
        CAPTURE, POST: begin
          if (do_write)
            wr_ptr <= wr_ptr + PW'(1);
          if (capturing && !full)
            count <= count + CW'(1);
          if (capturing && full) begin
            overflow <= 1'b1;
            if (RING_MODE != 0)
              rd_ptr <= rd_ptr + PW'(1);
          end
          if (st == CAPTURE && trap) begin
            st       <= (POST_TRIGGER == 0) ? DRAIN : POST;
            post_cnt <= PW'(POST_TRIGGER);
          end else if (st == POST && trace_valid) begin
            post_cnt <= post_cnt - PW'(1);
            if (post_cnt == PW'(1))
              st <= DRAIN;
          end
        end
        DRAIN: begin
          if (!out_valid || pop) begin
            if (more) begin
              out_data  <= mem[rd_ptr];
              rd_ptr    <= rd_ptr + PW'(1);
              out_valid <= 1'b1;
            end else begin
              out_valid <= 1'b0;
            end
          end
          count <= count - CW'(pop);
          // empty with nothing pending, or the last word just left
          if (count == CW'(pop))
            st <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule
